bcd_scan_ctrl: RTL and testbench

Two-digit display controller for the switch-to-7-segment path. It accepts a 4-bit binary value through a valid/ready handshake and converts it to tens/units BCD. It time-multiplexes the two digits onto one shared BCD digit bus with active-low digit enables. New values are committed only at scan-frame boundaries so the display never tears; the BCD bus feeds the team's 7-segment decoder.

---
 rtl/bcd_scan_ctrl.sv | 125 ++++++++++++
 tb/tb_bcd_scan_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_ctrl.sv
// Two-digit BCD scan controller: accepts a 4-bit value through valid/ready and
// time-multiplexes tens/units onto one BCD bus, committing new values only at frame boundaries.
module bcd_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] bin_in,
  input  logic       load_valid,
  output logic       load_ready,
  output logic [3:0] digit_bcd,
  output logic [1:0] digit_sel,
  output logic [3:0] value_q,
  output logic       frame_done
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(REFRESH_DIV - 1);
  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [1:0] SEL_UNITS = 2'b10;
  localparam logic [1:0] SEL_TENS  = 2'b01;
  localparam logic [1:0] SEL_OFF   = 2'b11;

  typedef enum logic {
    UNI = 1'b0,
    DEC = 1'b1
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] div_cnt, div_cnt_d;
  logic [3:0]       pend, pend_d;
  logic             ready, ready_d;
  logic [3:0]       value, value_d;
  logic [3:0]       bcd, bcd_d;
  logic [1:0]       sel, sel_d;
  logic             fdone, fdone_d;

  logic             terminal;
  logic             boundary;
  logic             accept;
  logic             commit;
  logic             tens;
  logic [3:0]       units;

  // State, counter, handshake and display registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= UNI;
      div_cnt <= '0;
      pend    <= '0;
      ready   <= 1'b1;
      value   <= '0;
      bcd     <= '0;
      sel     <= SEL_UNITS;
      fdone   <= 1'b0;
    end else begin
      state   <= state_d;
      div_cnt <= div_cnt_d;
      pend    <= pend_d;
      ready   <= ready_d;
      value   <= value_d;
      bcd     <= bcd_d;
      sel     <= sel_d;
      fdone   <= fdone_d;
    end
  end

  // Next-state, commit and digit selection
  always_comb begin
    state_d   = state;
    div_cnt_d = div_cnt + CNT_W'(1);
    pend_d    = pend;
    ready_d   = ready;
    value_d   = value;
    bcd_d     = bcd;
    sel_d     = sel;
    fdone_d   = 1'b0;
    tens      = 1'b0;
    units     = '0;

    terminal = (div_cnt == TERM_CNT);
    boundary = terminal && (state == DEC);
    accept   = load_valid && ready;
    commit   = boundary && !ready;

    if (terminal) begin
      div_cnt_d = '0;
      state_d   = (state == UNI) ? DEC : UNI;
    end

    // Accept and commit are mutually exclusive: accept needs an empty slot, commit a full one
    if (accept) begin
      pend_d  = bin_in;
      ready_d = 1'b0;
    end else if (commit) begin
      value_d = pend;
      ready_d = 1'b1;
    end

    // Pulse is registered so it is high during the boundary cycle itself
    fdone_d = (state_d == DEC) && (div_cnt_d == TERM_CNT);

    tens  = (value_d >= 4'd10);
    units = tens ? (value_d - 4'd10) : value_d;

    if (state_d == UNI) begin
      sel_d = SEL_UNITS;
      bcd_d = units;
    end else if (!tens && BLANK_LZ) begin
      sel_d = SEL_OFF;
      bcd_d = BCD_BLANK;
    end else begin
      sel_d = SEL_TENS;
      bcd_d = {3'b000, tens};
    end
  end

  assign load_ready = ready;
  assign digit_bcd  = bcd;
  assign digit_sel  = sel;
  assign value_q    = value;
  assign frame_done = fdone;

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Directed bench for bcd_scan_ctrl with REFRESH_DIV=4: one instance blanks the
// leading zero, the other always shows it. Outputs are sampled on the falling edge.
module tb_bcd_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] bin_a, bin_b;
  logic       valid_a, valid_b;
  logic       ready_a, ready_b;
  logic [3:0] bcd_a, bcd_b;
  logic [1:0] sel_a, sel_b;
  logic [3:0] val_a, val_b;
  logic       fd_a, fd_b;

  int n_cmp;
  int n_err;
  int cyc;

  logic [3:0] exp_units [16] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                                 4'd8, 4'd9, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
  logic [3:0] exp_tens  [16] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0,
                                 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};

  bcd_scan_ctrl #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bin_in(bin_a), .load_valid(valid_a),
    .load_ready(ready_a), .digit_bcd(bcd_a), .digit_sel(sel_a),
    .value_q(val_a), .frame_done(fd_a)
  );

  bcd_scan_ctrl #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bin_in(bin_b), .load_valid(valid_b),
    .load_ready(ready_b), .digit_bcd(bcd_b), .digit_sel(sel_b),
    .value_q(val_b), .frame_done(fd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic goto(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_sel",   {2'b00, sel_a}, 4'b0010);
    chk("rst_bcd",   bcd_a, 4'h0);
    chk("rst_value", val_a, 4'h0);
    chk("rst_ready", {3'b000, ready_a}, 4'h1);
    chk("rst_fdone", {3'b000, fd_a}, 4'h0);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0;
    rst_n = 1'b0;
    bin_a = '0; bin_b = '0; valid_a = 1'b0; valid_b = 1'b0;

    // Idle: units 0 for 4 cycles, blanked tens for 4, frame pulse on cycle 7
    do_reset();
    for (int c = 0; c < 16; c++) begin
      chk("idle_sel", {2'b00, sel_a}, ((c % 8) < 4) ? 4'b0010 : 4'b0011);
      chk("idle_bcd", bcd_a, ((c % 8) < 4) ? 4'h0 : 4'hF);
      chk("idle_fd",  {3'b000, fd_a}, ((c % 8) == 7) ? 4'h1 : 4'h0);
      tick();
    end

    // Load 13 at cycle 2, committed at the cycle-7 boundary
    do_reset();
    goto(2);
    bin_a = 4'd13; valid_a = 1'b1;
    tick();
    valid_a = 1'b0; bin_a = 4'd2;
    chk("ld13_ready_lo", {3'b000, ready_a}, 4'h0);
    goto(7);
    chk("ld13_fd", {3'b000, fd_a}, 4'h1);
    chk("ld13_val_old", val_a, 4'd0);
    tick();
    chk("ld13_val", val_a, 4'd13);
    chk("ld13_ready_hi", {3'b000, ready_a}, 4'h1);
    chk("ld13_fd_lo", {3'b000, fd_a}, 4'h0);
    for (int c = 8; c < 16; c++) begin
      chk("ld13_sel", {2'b00, sel_a}, (c < 12) ? 4'b0010 : 4'b0001);
      chk("ld13_bcd", bcd_a, (c < 12) ? 4'd3 : 4'd1);
      tick();
    end

    // Load 7 on a boundary cycle: held pending for a whole frame
    goto(23);
    chk("b7_fd", {3'b000, fd_a}, 4'h1);
    bin_a = 4'd7; valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    chk("b7_no_bypass", val_a, 4'd13);
    chk("b7_ready_lo", {3'b000, ready_a}, 4'h0);
    chk("b7_bcd_old", bcd_a, 4'd3);
    goto(31);
    chk("b7_fd2", {3'b000, fd_a}, 4'h1);
    chk("b7_val_old", val_a, 4'd13);
    tick();
    chk("b7_val", val_a, 4'd7);
    chk("b7_bcd", bcd_a, 4'd7);
    chk("b7_ready_hi", {3'b000, ready_a}, 4'h1);
    goto(36);
    chk("b7_blank_sel", {2'b00, sel_a}, 4'b0011);
    chk("b7_blank_bcd", bcd_a, 4'hF);

    // Back-pressure: 9 accepted, 15 held while not ready, 15 taken once ready
    bin_a = 4'd9; valid_a = 1'b1;
    tick();
    bin_a = 4'd15;
    chk("bp_ready_lo", {3'b000, ready_a}, 4'h0);
    goto(40);
    chk("bp_val9", val_a, 4'd9);
    chk("bp_bcd9", bcd_a, 4'd9);
    chk("bp_ready_hi", {3'b000, ready_a}, 4'h1);
    tick();
    valid_a = 1'b0;
    chk("bp_ready_15", {3'b000, ready_a}, 4'h0);
    chk("bp_val_still9", val_a, 4'd9);
    goto(48);
    chk("bp_val15", val_a, 4'd15);
    chk("bp_units15", bcd_a, 4'd5);
    goto(52);
    chk("bp_tens_sel", {2'b00, sel_a}, 4'b0001);
    chk("bp_tens_bcd", bcd_a, 4'd1);

    // Reset mid-DEC with 11 pending: it must be discarded
    bin_a = 4'd11; valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    chk("mr_pending", {3'b000, ready_a}, 4'h0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mr_async_sel", {2'b00, sel_a}, 4'b0010);
    chk("mr_async_bcd", bcd_a, 4'h0);
    chk("mr_async_val", val_a, 4'h0);
    chk("mr_async_ready", {3'b000, ready_a}, 4'h1);
    do_reset();
    for (int c = 0; c < 16; c++) begin
      chk("mr_val", val_a, 4'd0);
      chk("mr_bcd", bcd_a, ((c % 8) < 4) ? 4'h0 : 4'hF);
      tick();
    end

    // No blanking: load 5 then sweep 0..15; each value accepted at a frame start
    goto(32);
    for (int k = 0; k < 17; k++) begin
      logic [3:0] v;
      v = (k == 0) ? 4'd5 : 4'(k - 1);
      bin_b = v; valid_b = 1'b1;
      tick();
      valid_b = 1'b0;
      goto(cyc + 7);
      chk("sw_val", val_b, v);
      chk("sw_units_sel", {2'b00, sel_b}, 4'b0010);
      chk("sw_units", bcd_b, exp_units[v]);
      goto(cyc + 4);
      chk("sw_tens_sel", {2'b00, sel_b}, 4'b0001);
      chk("sw_tens", bcd_b, exp_tens[v]);
      goto(cyc + 4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
